// File: rtl/memoria_dados_2p.sv
// Dual-port data memory: port A read/write with byte enables, port B read-only, 1-cycle latency.
// Optional even parity per byte and erro_paridade output when MEM_DADOS_PARIDADE_EN is defined.
module memoria_dados_2p #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned INIT_ZERO = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  ocupado,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [DATA_W/8-1:0]   a_be,
    input  logic [ADDR_W-1:0]     a_end,
    input  logic [DATA_W-1:0]     a_dado,
    output logic [DATA_W-1:0]     a_saida,
    output logic                  a_valido,
    input  logic                  b_req,
    input  logic [ADDR_W-1:0]     b_end,
    output logic [DATA_W-1:0]     b_saida,
    output logic                  b_valido
`ifdef MEM_DADOS_PARIDADE_EN
    ,
    output logic                  erro_paridade
`endif
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    typedef enum logic {LIMPA, PRONTO} estado_t;

    estado_t             estado, prox_estado;
    logic [ADDR_W-1:0]   ptr;
    logic                limpa_we;
    logic                a_acc, a_wr, b_acc;
    logic [DATA_W-1:0]   a_mesclado, b_palavra;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= LIMPA;
            ptr    <= '0;
        end else begin
            estado <= prox_estado;
            if (estado == LIMPA)
                ptr <= ptr + 1'b1;
        end
    end

    always_comb begin
        prox_estado = estado;
        limpa_we    = 1'b0;
        ocupado     = 1'b0;
        case (estado)
            LIMPA: begin
                ocupado = 1'b1;
                if (INIT_ZERO != 0) begin
                    limpa_we = 1'b1;
                    if (ptr == PTR_MAX)
                        prox_estado = PRONTO;
                end else begin
                    prox_estado = PRONTO;
                end
            end
            default: prox_estado = PRONTO;
        endcase
    end

    always_comb begin
        a_acc      = a_req && !ocupado;
        a_wr       = a_acc && a_we;
        b_acc      = b_req && !ocupado;
        a_mesclado = mem[a_end];
        for (int unsigned i = 0; i < NB; i++)
            if (a_wr && a_be[i])
                a_mesclado[8*i +: 8] = a_dado[8*i +: 8];
        // write-first forwarding when B reads the word A is writing
        b_palavra = (a_wr && (a_end == b_end)) ? a_mesclado : mem[b_end];
    end

    always_ff @(posedge clock) begin
        if (limpa_we)
            mem[ptr] <= '0;
        else if (a_wr)
            mem[a_end] <= a_mesclado;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_saida  <= '0;
            b_saida  <= '0;
            a_valido <= 1'b0;
            b_valido <= 1'b0;
        end else begin
            a_valido <= a_acc;
            b_valido <= b_acc;
            if (a_acc)
                a_saida <= a_mesclado;
            if (b_acc)
                b_saida <= b_palavra;
        end
    end

`ifdef MEM_DADOS_PARIDADE_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] a_par_m, b_par;
    logic          a_erro, b_erro;

    function automatic logic [NB-1:0] paridade(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < NB; i++)
            p[i] = ^w[8*i +: 8];
        return p;
    endfunction

    always_comb begin
        a_par_m = par_mem[a_end];
        for (int unsigned i = 0; i < NB; i++)
            if (a_wr && a_be[i])
                a_par_m[i] = ^a_dado[8*i +: 8];
        b_par  = (a_wr && (a_end == b_end)) ? a_par_m : par_mem[b_end];
        a_erro = |(paridade(a_mesclado) ^ a_par_m);
        b_erro = |(paridade(b_palavra) ^ b_par);
    end

    always_ff @(posedge clock) begin
        if (limpa_we)
            par_mem[ptr] <= '0;
        else if (a_wr)
            par_mem[a_end] <= a_par_m;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            erro_paridade <= 1'b0;
        else
            erro_paridade <= (a_acc && a_erro) || (b_acc && b_erro);
    end
`endif

endmodule

// File: tb/tb_memoria_dados_2p.sv
// Randomized self-checking bench for memoria_dados_2p (DATA_W=16, ADDR_W=4) against a word-array model.
// Parity checks are compiled in only when MEM_DADOS_PARIDADE_EN is defined.
module tb_memoria_dados_2p;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ocupado;
    logic          a_req, a_we, b_req;
    logic [1:0]    a_be;
    logic [AW-1:0] a_end, b_end;
    logic [DW-1:0] a_dado, a_saida, b_saida;
    logic          a_valido, b_valido;
`ifdef MEM_DADOS_PARIDADE_EN
    logic          erro_paridade;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_a, last_b;

    memoria_dados_2p #(.DATA_W(DW), .ADDR_W(AW), .INIT_ZERO(1)) dut (
        .clock(clock), .reset(reset), .ocupado(ocupado),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_end(a_end), .a_dado(a_dado),
        .a_saida(a_saida), .a_valido(a_valido),
        .b_req(b_req), .b_end(b_end), .b_saida(b_saida), .b_valido(b_valido)
`ifdef MEM_DADOS_PARIDADE_EN
        , .erro_paridade(erro_paridade)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        a_req = 0; a_we = 0; a_be = '0; a_end = '0; a_dado = '0;
        b_req = 0; b_end = '0;
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        last_a = '0;
        last_b = '0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (ocupado && n < 100) begin
            n++;
            step();
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [1:0] be);
        logic [DW-1:0] mask;
        mask = {{8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    task automatic test_reset();
        int n;
        set_idle();
        reset = 1;
        step(); step();
        checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL reset_ocupado got %b want 1", ocupado); end
        checks++; if (a_saida !== 16'h0 || b_saida !== 16'h0) begin errors++; $display("FAIL reset_saida got %h/%h want 0000/0000", a_saida, b_saida); end
        checks++; if (a_valido !== 1'b0 || b_valido !== 1'b0) begin errors++; $display("FAIL reset_valido got %b/%b want 0/0", a_valido, b_valido); end
`ifdef MEM_DADOS_PARIDADE_EN
        checks++; if (erro_paridade !== 1'b0) begin errors++; $display("FAIL reset_paridade got %b want 0", erro_paridade); end
`endif
        reset = 0;
        count_busy(n);
        checks++; if (n != 16) begin errors++; $display("FAIL busy_len got %0d want 16", n); end
        zero_model();
    endtask

    task automatic test_clear_readback();
        for (int i = 0; i < DEPTH; i++) begin
            set_idle();
            a_req = 1; a_end = AW'(i);
            b_req = 1; b_end = AW'(DEPTH - 1 - i);
            step();
            checks++; if (a_valido !== 1'b1 || a_saida !== 16'h0) begin errors++; $display("FAIL clr_a[%0d] got v=%b d=%h want v=1 d=0000", i, a_valido, a_saida); end
            checks++; if (b_valido !== 1'b1 || b_saida !== 16'h0) begin errors++; $display("FAIL clr_b[%0d] got v=%b d=%h want v=1 d=0000", i, b_valido, b_saida); end
            set_idle();
            step();
            checks++; if (a_valido !== 1'b0 || b_valido !== 1'b0) begin errors++; $display("FAIL clr_pulse[%0d] got %b/%b want 0/0", i, a_valido, b_valido); end
        end
    endtask

    task automatic test_byte_enable();
        set_idle();
        a_req = 1; a_we = 1; a_end = 3; a_dado = 16'hBEEF; a_be = 2'b11;
        step();
        checks++; if (a_valido !== 1'b1 || a_saida !== 16'hBEEF) begin errors++; $display("FAIL be_full got v=%b d=%h want v=1 d=beef", a_valido, a_saida); end
        a_dado = 16'h1234; a_be = 2'b01;
        step();
        checks++; if (a_valido !== 1'b1 || a_saida !== 16'hBE34) begin errors++; $display("FAIL be_low got v=%b d=%h want v=1 d=be34", a_valido, a_saida); end
        a_dado = 16'h5555; a_be = 2'b00;
        step();
        checks++; if (a_valido !== 1'b1 || a_saida !== 16'hBE34) begin errors++; $display("FAIL be_none got v=%b d=%h want v=1 d=be34", a_valido, a_saida); end
        set_idle();
        b_req = 1; b_end = 3;
        step();
        checks++; if (b_valido !== 1'b1 || b_saida !== 16'hBE34) begin errors++; $display("FAIL be_b got v=%b d=%h want v=1 d=be34", b_valido, b_saida); end
        checks++; if (a_valido !== 1'b0 || a_saida !== 16'hBE34) begin errors++; $display("FAIL a_hold got v=%b d=%h want v=0 d=be34", a_valido, a_saida); end
        model[3] = 16'hBE34;
        last_a = 16'hBE34; last_b = 16'hBE34;
    endtask

    task automatic test_collision();
        set_idle();
        a_req = 1; a_we = 1; a_end = 5; a_dado = 16'hA5A5; a_be = 2'b11;
        b_req = 1; b_end = 5;
        step();
        checks++; if (b_valido !== 1'b1 || b_saida !== 16'hA5A5) begin errors++; $display("FAIL collision_b got v=%b d=%h want v=1 d=a5a5", b_valido, b_saida); end
        checks++; if (a_valido !== 1'b1 || a_saida !== 16'hA5A5) begin errors++; $display("FAIL collision_a got v=%b d=%h want v=1 d=a5a5", a_valido, a_saida); end
        model[5] = 16'hA5A5;
        last_a = 16'hA5A5; last_b = 16'hA5A5;
        set_idle();
    endtask

    task automatic test_busy_ignore();
        int n = 0;
        set_idle();
        reset = 1; step(); reset = 0;
        while (ocupado && n < 100) begin
            a_req = 1; a_we = 1; a_end = 2; a_dado = 16'hFFFF; a_be = 2'b11;
            b_req = 1; b_end = 2;
            step();
            n++;
            checks++; if (a_valido !== 1'b0 || b_valido !== 1'b0) begin errors++; $display("FAIL busy_valid[%0d] got %b/%b want 0/0", n, a_valido, b_valido); end
        end
        checks++; if (n != 16) begin errors++; $display("FAIL busy_len2 got %0d want 16", n); end
        zero_model();
        set_idle();
        a_req = 1; a_end = 2;
        step();
        checks++; if (a_valido !== 1'b1 || a_saida !== 16'h0) begin errors++; $display("FAIL busy_read got v=%b d=%h want v=1 d=0000", a_valido, a_saida); end
        set_idle();
    endtask

    task automatic test_reset_midclear();
        int n;
        set_idle();
        a_req = 1; a_we = 1; a_end = 7; a_dado = 16'h00FF; a_be = 2'b11;
        step();
        checks++; if (a_saida !== 16'h00FF) begin errors++; $display("FAIL mid_write got %h want 00ff", a_saida); end
        set_idle();
        reset = 1; step(); reset = 0;
        for (int i = 0; i < 5; i++) step();
        reset = 1;
        #1;
        checks++; if (ocupado !== 1'b1 || a_saida !== 16'h0) begin errors++; $display("FAIL mid_async got ocupado=%b d=%h want 1/0000", ocupado, a_saida); end
        step();
        reset = 0;
        count_busy(n);
        checks++; if (n != 16) begin errors++; $display("FAIL mid_busy_len got %0d want 16", n); end
        zero_model();
        a_req = 1; a_end = 7;
        step();
        checks++; if (a_valido !== 1'b1 || a_saida !== 16'h0) begin errors++; $display("FAIL mid_read got v=%b d=%h want v=1 d=0000", a_valido, a_saida); end
        last_a = '0;
        set_idle();
        step();
    endtask

    task automatic test_back_to_back_random();
        logic          ar, aw, br;
        logic [1:0]    abe;
        logic [AW-1:0] ae, bea;
        logic [DW-1:0] ad, exp_a, exp_b;
        for (int k = 0; k < 400; k++) begin
            ar  = ($urandom_range(0, 3) != 0);
            aw  = $urandom_range(0, 1) == 1;
            br  = ($urandom_range(0, 3) != 0);
            abe = 2'($urandom_range(0, 3));
            ae  = AW'($urandom_range(0, DEPTH - 1));
            bea = ($urandom_range(0, 3) == 0) ? ae : AW'($urandom_range(0, DEPTH - 1));
            ad  = 16'($urandom);
            a_req = ar; a_we = aw; a_be = abe; a_end = ae; a_dado = ad;
            b_req = br; b_end = bea;
            exp_a = last_a;
            if (ar) begin
                if (aw) model[ae] = merge(model[ae], ad, abe);
                exp_a = model[ae];
            end
            exp_b = br ? model[bea] : last_b;
            step();
            checks++; if (a_valido !== ar || a_saida !== exp_a) begin errors++; $display("FAIL rnd_a[%0d] got v=%b d=%h want v=%b d=%h", k, a_valido, a_saida, ar, exp_a); end
            checks++; if (b_valido !== br || b_saida !== exp_b) begin errors++; $display("FAIL rnd_b[%0d] got v=%b d=%h want v=%b d=%h", k, b_valido, b_saida, br, exp_b); end
            last_a = exp_a;
            last_b = exp_b;
        end
        set_idle();
        step();
    endtask

`ifdef MEM_DADOS_PARIDADE_EN
    task automatic test_parity();
        set_idle();
        b_req = 1; b_end = 1;
        step();
        checks++; if (b_valido !== 1'b1 || erro_paridade !== 1'b0) begin errors++; $display("FAIL par_clean got v=%b e=%b want 1/0", b_valido, erro_paridade); end
        set_idle();
        dut.mem[1] = dut.mem[1] ^ 16'h0001;
        b_req = 1; b_end = 1;
        step();
        checks++; if (b_valido !== 1'b1 || erro_paridade !== 1'b1) begin errors++; $display("FAIL par_error got v=%b e=%b want 1/1", b_valido, erro_paridade); end
        set_idle();
        step();
        checks++; if (erro_paridade !== 1'b0) begin errors++; $display("FAIL par_pulse got %b want 0", erro_paridade); end
    endtask
`endif

    initial begin
        set_idle();
        zero_model();
        test_reset();
        test_clear_readback();
        test_byte_enable();
        test_collision();
        test_busy_ignore();
        test_reset_midclear();
        test_back_to_back_random();
`ifdef MEM_DADOS_PARIDADE_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
